// File: rtl/uni_bi_pkg.sv
// Shared types and helpers for the unipolar/bipolar stream converter.
// Provides the conversion mode enum and the accumulator width function.
package uni_bi_pkg;

    typedef enum logic {
        UNI2BI = 1'b0,
        BI2UNI = 1'b1
    } conv_mode_e;

    // Signed width able to hold -debt_max .. +1 with headroom.
    function automatic int acc_width(input int debt_max);
        return $clog2(debt_max + 1) + 1;
    endfunction

endpackage

// File: rtl/uni_bi_conv_cell.sv
// Single-channel stream converter: one accumulator plus output flop.
// Ports: clk, rst (sync, active-high), mode (current mode), clear
// (zero the accumulator before use), valid, in (stream bit), out.
module uni_bi_conv_cell
    import uni_bi_pkg::*;
#(
    parameter int DEBT_MAX = 7,
    parameter int ACC_W    = acc_width(DEBT_MAX)
) (
    input  logic       clk,
    input  logic       rst,
    input  conv_mode_e mode,
    input  logic       clear,
    input  logic       valid,
    input  logic       in,
    output logic       out
);

    // One extra bit so a + 1 or a - 1 can never wrap.
    localparam int TW = ACC_W + 1;
    typedef logic signed [TW-1:0] wide_t;

    localparam wide_t ONE   = wide_t'(1);
    localparam wide_t TWO   = wide_t'(2);
    localparam wide_t FLOOR = wide_t'(-DEBT_MAX);

    logic signed [ACC_W-1:0] acc;
    wide_t                   a;
    wide_t                   t;
    wide_t                   acc_nxt;
    logic                    out_nxt;

    always_comb begin
        a       = clear ? '0 : wide_t'(acc);
        t       = '0;
        acc_nxt = a;
        out_nxt = 1'b0;
        if (valid) begin
            unique case (mode)
                UNI2BI: begin
                    t = a + wide_t'(in) + ONE;
                    if (t >= TWO) begin
                        out_nxt = 1'b1;
                        acc_nxt = t - TWO;
                    end else begin
                        acc_nxt = t;
                    end
                end
                BI2UNI: begin
                    t = in ? a + ONE : a - ONE;
                    if (t >= ONE) begin
                        out_nxt = 1'b1;
                        acc_nxt = t - ONE;
                    end else begin
                        // Debt beyond the floor is dropped: this is the clip.
                        acc_nxt = (t < FLOOR) ? FLOOR : t;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            out <= 1'b0;
        end else begin
            acc <= acc_nxt[ACC_W-1:0];
            out <= out_nxt;
        end
    end

    acc_range: assert property (
        @(posedge clk) disable iff (rst)
        (wide_t'(acc) >= FLOOR) && (wide_t'(acc) <= ONE)
    );

endmodule

// File: rtl/uni_bi_conv_array.sv
// N-channel runtime-selectable unipolar <-> bipolar stream converter.
// Ports: clk, rst (sync, active-high), mode (0 UNI2BI, 1 BI2UNI), clr,
// in_valid, in[N], out_valid (registered in_valid), out[N] (registered).
module uni_bi_conv_array
    import uni_bi_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int DEBT_MAX = 7,
    localparam int ACC_W    = acc_width(DEBT_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [N-1:0] in,
    output logic         out_valid,
    output logic [N-1:0] out
);

    conv_mode_e mode_cur;
    conv_mode_e mode_q;
    logic       mode_chg;
    logic       clear;

    assign mode_cur = conv_mode_e'(mode);
    assign mode_chg = (mode_cur != mode_q);
    // A mode switch restarts every lane from an empty accumulator.
    assign clear    = clr | mode_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= UNI2BI;
            out_valid <= 1'b0;
        end else begin
            mode_q    <= mode_cur;
            out_valid <= in_valid;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        uni_bi_conv_cell #(
            .DEBT_MAX (DEBT_MAX),
            .ACC_W    (ACC_W)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .mode  (mode_cur),
            .clear (clear),
            .valid (in_valid),
            .in    (in[i]),
            .out   (out[i])
        );
    end

endmodule

// File: tb/tb_uni_bi_conv_array.sv
// Directed self-checking bench for uni_bi_conv_array.
// Table-driven stream vectors plus hand-written saturation/count runs.
module tb_uni_bi_conv_array;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       clr;
    logic       in_valid;
    logic [7:0] din;
    logic       out_valid;
    logic [7:0] dout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       mode;
        logic       clr;
        logic       vld;
        logic [7:0] din;
        logic       exp_v;
        logic [7:0] exp_o;
    } vec_t;

    vec_t tbl[$];

    uni_bi_conv_array #(
        .N        (8),
        .DEBT_MAX (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .clr       (clr),
        .in_valid  (in_valid),
        .in        (din),
        .out_valid (out_valid),
        .out       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic m,
                                input logic c, input logic v,
                                input logic [7:0] d,
                                input logic ev, input logic [7:0] eo);
        vec_t x;
        x.rst   = r;
        x.mode  = m;
        x.clr   = c;
        x.vld   = v;
        x.din   = d;
        x.exp_v = ev;
        x.exp_o = eo;
        return x;
    endfunction

    task automatic step(input logic r, input logic m, input logic c,
                        input logic v, input logic [7:0] d);
        rst      = r;
        mode     = m;
        clr      = c;
        in_valid = v;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eo,
                         input logic ev);
        checks++;
        if (dout !== eo || out_valid !== ev) begin
            failures++;
            $display("FAIL %s: out=%h out_valid=%b, expected out=%h out_valid=%b",
                     name, dout, out_valid, eo, ev);
        end
    endtask

    // UNI2BI, ch0 in=0, ch1 in=1, ch2 pattern 1110, ch3..7 in=0.
    logic [7:0] uni_exp [8] = '{8'h06, 8'hFF, 8'h06, 8'hFB,
                                8'h06, 8'hFF, 8'h06, 8'hFF};

    function automatic logic [7:0] uni_in(input int k);
        return (k % 4 == 3) ? 8'h02 : 8'h06;
    endfunction

    initial begin
        int ones0;
        int ones1;
        int ones2;
        logic [7:0] e;

        rst      = 1'b1;
        mode     = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        din      = '0;

        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 1, uni_in(k), 1, uni_exp[k % 8]));
        for (int g = 0; g < 3; g++)
            tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 0, 8'h00));
        for (int k = 5; k < 20; k++) begin
            e = uni_exp[k % 8];
            if (k == 17) e = 8'h06;
            if (k == 18) e = 8'hFF;
            if (k == 19) e = 8'h02;
            tbl.push_back(mk(0, 0, (k == 17), 1, uni_in(k), 1, e));
        end
        tbl.push_back(mk(1, 0, 0, 1, 8'h06, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 8'h06, 1, 8'h06));
        tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 1, 8'hFF));
        tbl.push_back(mk(0, 1, 0, 1, 8'h00, 1, 8'h00));
        tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 1, 8'h00));
        tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 1, 8'hFF));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].mode, tbl[i].clr, tbl[i].vld, tbl[i].din);
            check($sformatf("vec%0d", i), tbl[i].exp_o, tbl[i].exp_v);
        end

        // BI2UNI debt saturation: 10 zeros, then ones.
        step(1, 1, 0, 0, 8'h00);
        check("bi_reset", 8'h00, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step(0, 1, 0, 1, 8'h00);
            check($sformatf("bi_zero%0d", j), 8'h00, 1'b1);
        end
        for (int j = 0; j < 10; j++) begin
            step(0, 1, 0, 1, 8'hFF);
            check($sformatf("bi_recover%0d", j), (j < 7) ? 8'h00 : 8'hFF, 1'b1);
        end

        // BI2UNI density: ch0 pattern 1110, ch1 all ones, ch2 all zeros.
        step(1, 1, 0, 0, 8'h00);
        ones0 = 0;
        ones1 = 0;
        ones2 = 0;
        for (int k = 0; k < 400; k++) begin
            step(0, 1, 0, 1, (k % 4 == 3) ? 8'h02 : 8'h03);
            ones0 += int'(dout[0]);
            ones1 += int'(dout[1]);
            ones2 += int'(dout[2]);
        end
        checks++;
        if (ones0 != 201) begin
            failures++;
            $display("FAIL bi_count_1110: ones=%0d expected 201", ones0);
        end
        checks++;
        if (ones1 != 400) begin
            failures++;
            $display("FAIL bi_count_ones: ones=%0d expected 400", ones1);
        end
        checks++;
        if (ones2 != 0) begin
            failures++;
            $display("FAIL bi_count_zeros: ones=%0d expected 0", ones2);
        end

        step(0, 1, 0, 0, 8'h00);
        check("final_idle", 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
